// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and the data bus. A store retires 2 cycles after lsu_valid, a load 3 (zero-wait bus).
// The core is stalled until retire, and mem_req is held until mem_gnt. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_ctrl #(
   parameter int          ADDR_W    = 32,
   parameter logic [31:0] RDATA_RST = 32'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lsu_valid,
   input  logic              lsu_we,
   input  logic [2:0]        lsu_funct3,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [31:0]       lsu_wdata,
   output logic              lsu_stall,
   output logic              lsu_done,
   output logic [31:0]       lsu_rdata,
   output logic              lsu_misaligned,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t      state, state_nxt;
   logic        we_q, uns_q;
   logic [1:0]  sz_q, off_q;
   logic [1:0]  sz_in;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;
   logic        trap_in;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // Access size: 0=byte, 1=half, 2=word; reserved encodings fall into word.
   always_comb begin
      case (lsu_funct3)
         3'b000, 3'b100: sz_in = 2'd0;
         3'b001, 3'b101: sz_in = 2'd1;
         default:        sz_in = 2'd2;
      endcase
      be_in    = 4'b1111;
      wdata_in = lsu_wdata;
      case (sz_in)
         2'd0: begin
            be_in    = 4'b0001 << lsu_addr[1:0];
            wdata_in = {4{lsu_wdata[7:0]}};
         end
         2'd1: begin
            be_in    = lsu_addr[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{lsu_wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_q;
   assign trap_in = ((sz_in == 2'd1) && lsu_addr[0]) ||
                    ((sz_in == 2'd2) && (lsu_addr[1:0] != 2'b00));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          mis_q <= 1'b0;
      else if (state == IDLE && lsu_valid) mis_q <= trap_in;
   end
   assign lsu_misaligned = mis_q && (state == DONE);
`else
   assign trap_in        = 1'b0;
   assign lsu_misaligned = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (lsu_valid) state_nxt = trap_in ? DONE : REQ;
         REQ:     if (mem_gnt)   state_nxt = we_q ? DONE : RESP;
         RESP:    if (mem_rvalid) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   assign mem_req   = (state == REQ);
   assign mem_we    = mem_req && we_q;
   assign lsu_done  = (state == DONE);
   assign lsu_stall = lsu_valid && !lsu_done;

   always_comb begin
      case (off_q)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (sz_q)
         2'd0:    load_ext = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'd1:    load_ext = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q      <= 1'b0;
         uns_q     <= 1'b0;
         sz_q      <= 2'd0;
         off_q     <= 2'd0;
         mem_addr  <= '0;
         mem_be    <= 4'h0;
         mem_wdata <= 32'h0;
         lsu_rdata <= RDATA_RST;
      end else begin
         if (state == IDLE && lsu_valid) begin
            we_q      <= lsu_we;
            uns_q     <= lsu_funct3[2];
            sz_q      <= sz_in;
            off_q     <= lsu_addr[1:0];
            mem_addr  <= {lsu_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= be_in;
            mem_wdata <= wdata_in;
         end
         if (state == RESP && mem_rvalid) lsu_rdata <= load_ext;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed and randomized bench for lsu_ctrl, checked against a behavioural access model.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst_n;
   logic        lsu_valid;
   logic        lsu_we;
   logic [2:0]  lsu_funct3;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic        lsu_stall;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic        lsu_misaligned;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int          n_cmp;
   int          n_err;
   logic [31:0] model_rd;

   lsu_ctrl #(.ADDR_W(32), .RDATA_RST(32'h0)) dut (
      .clk(clk), .rst_n(rst_n),
      .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
      .lsu_misaligned(lsu_misaligned),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] rd);
      int          sz;
      logic [31:0] v;
      sz = size_of(f3);
      if (sz == 1) begin
         v = (rd >> (8 * (addr % 4))) & 32'hFF;
         if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = (rd >> ((addr % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
         if (f3 == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // One access: gd = cycles of withheld grant, rvd = idle RESP cycles before rvalid.
   task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int gd, input int rvd);
      int          sz, exp_lat, reqn, gnt_c, done_c;
      bit          trap;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [7:0]  b;
      logic [15:0] h;
      sz   = size_of(f3);
      trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      trap = ((addr % sz) != 0);
`endif
      b = wd[7:0];
      h = wd[15:0];
      if (sz == 1) begin
         ebe = 4'b0001 << (addr % 4);
         ewd = {b, b, b, b};
      end else if (sz == 2) begin
         ebe = (addr % 4 >= 2) ? 4'b1100 : 4'b0011;
         ewd = {h, h};
      end else begin
         ebe = 4'b1111;
         ewd = wd;
      end
      if (trap)    exp_lat = 1;
      else if (we) exp_lat = 2 + gd;
      else         exp_lat = 3 + gd + rvd;
      if (!we && !trap) model_rd = extend(f3, addr, rd);

      lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
      reqn = 0; gnt_c = -1; done_c = -1;
      for (int c = 0; c < 20 && done_c < 0; c++) begin
         @(negedge clk);
         mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         if (mem_req) begin
            chk("req_window", 32'(gnt_c < 0 && !trap), 32'd1);
            chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("mem_be", 32'(mem_be), 32'(ebe));
            chk("mem_we", 32'(mem_we), 32'(we));
            if (we) chk("mem_wdata", mem_wdata, ewd);
            if (reqn == gd) begin
               mem_gnt = 1'b1;
               gnt_c   = c;
            end else begin
               mem_rvalid = 1'($urandom % 2);
            end
            reqn++;
         end else if (!we && gnt_c >= 0 && c == gnt_c + 1 + rvd) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
         end
         if (lsu_done) begin
            done_c = c;
            chk("stall_done", 32'(lsu_stall), 32'd0);
            chk("misaligned", 32'(lsu_misaligned), 32'(trap));
            chk("rdata", lsu_rdata, model_rd);
         end else begin
            chk("stall_busy", 32'(lsu_stall), 32'd1);
         end
         @(posedge clk); #1;
      end
      chk("latency", 32'(done_c), 32'(exp_lat));
      lsu_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; model_rd = 32'h0;
      rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0;
      lsu_addr = 32'h0; lsu_wdata = 32'h0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_done", 32'(lsu_done), 32'd0);
      chk("rst_mis", 32'(lsu_misaligned), 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_be", 32'(mem_be), 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_rdata", lsu_rdata, 32'h0);
      chk("rst_stall", 32'(lsu_stall), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      access(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
      access(1'b1, 3'd0, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
      access(1'b0, 3'd0, 32'h102, 32'h0, 32'h0080_FF00, 0, 0);
      chk("lb_value", lsu_rdata, 32'hFFFF_FF80);
      access(1'b0, 3'd4, 32'h102, 32'h0, 32'h0080_FF00, 0, 0);
      chk("lbu_value", lsu_rdata, 32'h0000_0080);
      access(1'b0, 3'd1, 32'h202, 32'h0, 32'h8001_1234, 3, 0);
      chk("lh_value", lsu_rdata, 32'hFFFF_8001);
      access(1'b1, 3'd1, 32'h206, 32'h1234_5678, 32'h0, 1, 0);
      chk("store_keeps_rdata", lsu_rdata, 32'hFFFF_8001);
      access(1'b0, 3'd2, 32'h101, 32'h0, 32'hCAFE_F00D, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
      chk("lw_trap_rdata", lsu_rdata, 32'hFFFF_8001);
`else
      chk("lw_aligned_rdata", lsu_rdata, 32'hCAFE_F00D);
`endif

      // Reset while the load waits for its response; the late rvalid must not retire it.
      lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'd2; lsu_addr = 32'h300;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rr_req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      lsu_valid = 1'b0;
      chk("rr_req_off", 32'(mem_req), 32'd0);
      chk("rr_rdata", lsu_rdata, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_rd = 32'h0;
      mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rr_no_done", 32'(lsu_done), 32'd0);
         chk("rr_hold", lsu_rdata, 32'h0);
      end
      mem_rvalid = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 40; i++) begin
         logic [2:0] f3;
         f3 = 3'($urandom_range(0, 7));
         access(1'($urandom % 2), f3, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting between the execute stage and the data-memory bus of the single-cycle core. Consumes the core's load_store funct3 encoding (LB_SB/LH_SH/LW_SW/LBU/LHU) plus the computed address and store data. Drives a valid/grant/rvalid memory handshake and returns an aligned, sign- or zero-extended load result. Stalls the core until the access retires.

Parameters:
ADDR_W, 32, byte-address width on core side and bus side
RDATA_RST, 32'h0, reset/idle value of lsu_rdata

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
lsu_valid  in  1  core presents a memory instruction; held stable while lsu_stall=1
lsu_we  in  1  1=store, 0=load
lsu_funct3  in  3  load_store encoding
lsu_addr  in  ADDR_W  effective byte address
lsu_wdata  in  32  rs2 store data, unaligned (byte/half in low bits)
lsu_stall  out  1  freeze PC/writeback
lsu_done  out  1  one-cycle retire pulse; rdata valid for loads
lsu_rdata  out  32  extended load result
lsu_misaligned  out  1  misaligned access flag (see Optional Feature)
mem_req  out  1  bus request
mem_we  out  1  bus write enable
mem_addr  out  ADDR_W  word-aligned address (low 2 bits = 0)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-shifted store data
mem_gnt  in  1  bus accepts request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; mem_req, mem_we, lsu_done, lsu_misaligned=0; mem_addr, mem_be, mem_wdata=0; lsu_rdata=RDATA_RST.
- lsu_stall = lsu_valid & ~lsu_done (combinational).
- FSM states IDLE, REQ, RESP, DONE.
- IDLE: on lsu_valid, latch we, funct3, addr, wdata; compute be/wdata lanes; -> REQ. Else stay.
- REQ: mem_req=1 with registered addr/be/wdata/we held stable until mem_gnt. On gnt: store -> DONE; load -> RESP.
- RESP: wait for mem_rvalid. Capture mem_rdata, select lane by addr[1:0], extend, register into lsu_rdata; -> DONE.
- mem_rvalid outside RESP is ignored.
- DONE: lsu_done=1 for exactly one cycle; -> IDLE unconditionally. A new request is accepted on the following IDLE cycle.
- Minimum latency, lsu_valid at cycle N with zero-wait bus: store done at N+2; load done at N+3.
- Byte enables:
  - SB: be = 4'b0001 << addr[1:0]; wdata byte replicated to all 4 lanes.
  - SH: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); halfword replicated to both lanes.
  - SW: be = 1111.
- Load extension: LB/LH sign-extend bit 7/15 of the selected lane; LBU/LHU zero-extend; LW passes the word through.
- Reserved funct3 (011, 110, 111) are treated as LW_SW.
- lsu_rdata holds its value after DONE until the next load retires; stores do not change it.
- Reset mid-access: immediate return to IDLE; an outstanding bus grant/response is discarded. No partial retire.
- lsu_valid dropping while in REQ/RESP is a core protocol violation; the FSM still completes the access.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: in IDLE, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 skips the bus entirely and goes IDLE -> DONE. lsu_misaligned=1 together with lsu_done; mem_req stays 0; lsu_rdata is unchanged.
- Undefined: lsu_misaligned is tied to 0 and low address bits below the access size are ignored: halfword uses addr[1], word uses the aligned word.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt immediate -> mem_addr=0x100, be=1111, wdata=0xDEADBEEF; done at N+2; 2 stall cycles.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x102, rdata=0x0080FF00, rvalid one cycle after gnt -> lsu_rdata=0xFFFFFF80; LBU same address -> 0x00000080.
- LH addr=0x202, mem_rdata=0x8001_1234, gnt delayed 3 cycles -> mem_req/addr/be held all 3 cycles, be=1100, lsu_rdata=0xFFFF8001, done N+6.
- rst_n low while in RESP, rvalid arriving afterwards -> IDLE, no lsu_done, lsu_rdata=RDATA_RST.
- With LSU_MISALIGN_TRAP_EN, LW addr=0x101 -> no mem_req, lsu_done and lsu_misaligned high at N+1. Without the macro -> normal access to 0x100.
